id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register with load-use hazard detection, bubble insertion and flush.
//  Captures decoded operands and control from ID and presents them to EX.
//  Supplies ex_rs1/ex_rs2 to the forwarding unit and ex_rd/ex_reg_write toward MEM.
//  Asserts stall to freeze PC and IF/ID on a load-use hazard or an EX hold.
// PARAMETERS
//  DATA_W     16  operand/immediate width
//  REG_AW     4   register address width; register 0 is hardwired zero
//  ALUOP_W    4   ALU opcode width
// PORTS
//  clk            in   1        rising-edge clock
//  rst            in   1        asynchronous, active-high reset
//  id_valid       in   1        ID holds a real instruction
//  id_rs1         in   REG_AW   source register 1
//  id_rs2         in   REG_AW   source register 2
//  id_uses_rs2    in   1        instruction reads rs2
//  id_rd          in   REG_AW   destination register
//  id_rs1_data    in   DATA_W   register-file read data 1
//  id_rs2_data    in   DATA_W   register-file read data 2
//  id_imm         in   DATA_W   sign-extended immediate
//  id_alu_op      in   ALUOP_W  ALU opcode
//  id_alu_src     in   1        1 = operand B from immediate
//  id_reg_write   in   1        writes rd
//  id_mem_read    in   1        load
//  id_mem_write   in   1        store
//  ex_hold        in   1        EX is busy multi-cycle; freeze this stage
//  flush          in   1        taken branch/jump resolved; kill ID instruction
//  stall          out  1        freeze PC and IF/ID this cycle (combinational)
//  ex_valid       out  1        EX holds a real instruction
//  ex_rs1, ex_rs2 out  REG_AW   registered source addresses
//  ex_rd          out  REG_AW   registered destination
//  ex_rs1_data    out  DATA_W   registered operand 1
//  ex_rs2_data    out  DATA_W   registered operand 2
//  ex_imm         out  DATA_W   registered immediate
//  ex_alu_op      out  ALUOP_W  registered opcode
//  ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write  out  1  registered control
// BEHAVIOUR
//  - Reset (async): every registered output is 0, so EX holds a bubble.
//  - load_use = ex_valid & ex_mem_read & (ex_rd!=0) & id_valid &
//      (ex_rd==id_rs1 | (id_uses_rs2 & ex_rd==id_rs2)).
//  - stall = (load_use | ex_hold) & ~flush. This is combinational and has no cycle of latency.
//  - Register update on each clk edge, highest priority first:
//      1 flush: load a bubble.
//      2 ex_hold: keep all registers unchanged.
//      3 load_use: load a bubble. ID is frozen by stall and is re-presented next cycle.
//      4 otherwise: capture all id_* fields. ex_valid <= id_valid.
//  - Bubble: ex_valid, ex_reg_write, ex_mem_read and ex_mem_write are 0.
//    ex_rd, ex_rs1 and ex_rs2 are 0. Data, imm and alu fields are don't-care but are driven to 0.
//  - Capture with id_valid=0: write-enable controls are forced to 0 (ex_reg_write, ex_mem_read, ex_mem_write).
//  - Load-use detection never fires against rd=0 or an invalid ID slot.
//  - A load-use stall lasts exactly 1 cycle. On the next cycle EX holds the bubble, so load_use is 0.
//  - flush together with load_use or ex_hold: flush wins, stall=0, and a bubble is loaded.
//  - Reset deasserted mid-stream: the first edge after deassertion follows the normal rules.
// CONFIGURATION
//  ID_EX_PERF_CNT_EN defined:
//    adds outputs stall_cnt[15:0] and flush_cnt[15:0].
//    stall_cnt increments on each edge where load_use is 1 and both flush and ex_hold are 0.
//    flush_cnt increments on each edge where flush is 1.
//    Both counters saturate at 16'hFFFF and are cleared by rst.
//  ID_EX_PERF_CNT_EN undefined: the counters and ports do not exist; behaviour is otherwise identical.
// TESTING
//  1 Pass-through: id_valid=1, rs1=2, rs2=3, rd=4, reg_write=1, no hazard.
//    -> next edge: ex_rd=4, ex_reg_write=1, ex_valid=1, stall=0.
//  2 Load-use: EX holds a load with rd=5; ID has rs1=5.
//    -> stall=1 that cycle; next edge loads a bubble (ex_valid=0); the following edge captures ID; stall=1 for only 1 cycle.
//  3 rd=0 / rs2 unused: EX holds a load with rd=0 and ID rs1=0 -> stall=0.
//    EX holds a load with rd=6, ID rs2=6 and id_uses_rs2=0 -> stall=0.
//  4 Flush with hazard: load_use=1 and flush=1 together.
//    -> stall=0, next edge ex_valid=0 and ex_mem_read=0.
//  5 Hold: ex_hold=1 for 3 cycles with EX holding rd=7.
//    -> ex_* unchanged for 3 edges and stall=1 throughout.
//    After release, the next ID instruction is captured.
//  6 Reset mid-operation: assert rst between edges while ex_valid=1.
//    -> all ex_* outputs are 0 immediately.
//    With ID_EX_PERF_CNT_EN, 70000 load-use stalls -> stall_cnt=16'hFFFF.

Source files
------------

// File: rtl/id_ex_if.sv
// ID/EX stage bundle: decoded ID fields going in, registered EX fields and
// the stall request coming out. The master side is the decode/control logic
// feeding the stage, and the slave side is the pipeline register itself.
interface id_ex_if #(
    parameter int DATA_W  = 16,
    parameter int REG_AW  = 4,
    parameter int ALUOP_W = 4
);
    // ID side
    logic               id_valid;
    logic [REG_AW-1:0]  id_rs1;
    logic [REG_AW-1:0]  id_rs2;
    logic               id_uses_rs2;
    logic [REG_AW-1:0]  id_rd;
    logic [DATA_W-1:0]  id_rs1_data;
    logic [DATA_W-1:0]  id_rs2_data;
    logic [DATA_W-1:0]  id_imm;
    logic [ALUOP_W-1:0] id_alu_op;
    logic               id_alu_src;
    logic               id_reg_write;
    logic               id_mem_read;
    logic               id_mem_write;
    // pipeline control
    logic               ex_hold;
    logic               flush;
    logic               stall;
    // EX side
    logic               ex_valid;
    logic [REG_AW-1:0]  ex_rs1;
    logic [REG_AW-1:0]  ex_rs2;
    logic [REG_AW-1:0]  ex_rd;
    logic [DATA_W-1:0]  ex_rs1_data;
    logic [DATA_W-1:0]  ex_rs2_data;
    logic [DATA_W-1:0]  ex_imm;
    logic [ALUOP_W-1:0] ex_alu_op;
    logic               ex_alu_src;
    logic               ex_reg_write;
    logic               ex_mem_read;
    logic               ex_mem_write;

    modport master (
        output id_valid, id_rs1, id_rs2, id_uses_rs2, id_rd, id_rs1_data,
               id_rs2_data, id_imm, id_alu_op, id_alu_src, id_reg_write,
               id_mem_read, id_mem_write, ex_hold, flush,
        input  stall, ex_valid, ex_rs1, ex_rs2, ex_rd, ex_rs1_data,
               ex_rs2_data, ex_imm, ex_alu_op, ex_alu_src, ex_reg_write,
               ex_mem_read, ex_mem_write
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_uses_rs2, id_rd, id_rs1_data,
               id_rs2_data, id_imm, id_alu_op, id_alu_src, id_reg_write,
               id_mem_read, id_mem_write, ex_hold, flush,
        output stall, ex_valid, ex_rs1, ex_rs2, ex_rd, ex_rs1_data,
               ex_rs2_data, ex_imm, ex_alu_op, ex_alu_src, ex_reg_write,
               ex_mem_read, ex_mem_write
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion
// and flush. Register update priority: flush > ex_hold > load-use > capture.
// Optional feature macro: ID_EX_PERF_CNT_EN adds saturating stall_cnt and
// flush_cnt performance counters.
module id_ex_stage #(
    parameter int DATA_W  = 16,
    parameter int REG_AW  = 4,
    parameter int ALUOP_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    id_ex_if.slave      bus
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
`endif
);

    typedef struct packed {
        logic               valid;
        logic [REG_AW-1:0]  rs1;
        logic [REG_AW-1:0]  rs2;
        logic [REG_AW-1:0]  rd;
        logic [DATA_W-1:0]  rs1_data;
        logic [DATA_W-1:0]  rs2_data;
        logic [DATA_W-1:0]  imm;
        logic [ALUOP_W-1:0] alu_op;
        logic               alu_src;
        logic               reg_write;
        logic               mem_read;
        logic               mem_write;
    } ex_slot_t;

    ex_slot_t ex_r;
    ex_slot_t capture_s;
    logic     load_use_s;

    // Load-use hazard: a valid load in EX targets a register ID is about to read.
    always_comb begin
        load_use_s = ex_r.valid & ex_r.mem_read & (ex_r.rd != {REG_AW{1'b0}}) &
                     bus.id_valid &
                     ((ex_r.rd == bus.id_rs1) |
                      (bus.id_uses_rs2 & (ex_r.rd == bus.id_rs2)));
    end

    // A flush kills the ID slot, so there is nothing left to hold back.
    assign bus.stall = (load_use_s | bus.ex_hold) & ~bus.flush;

    // Capture image of the ID slot; write enables are qualified by id_valid.
    always_comb begin
        capture_s           = '0;
        capture_s.valid     = bus.id_valid;
        capture_s.rs1       = bus.id_rs1;
        capture_s.rs2       = bus.id_rs2;
        capture_s.rd        = bus.id_rd;
        capture_s.rs1_data  = bus.id_rs1_data;
        capture_s.rs2_data  = bus.id_rs2_data;
        capture_s.imm       = bus.id_imm;
        capture_s.alu_op    = bus.id_alu_op;
        capture_s.alu_src   = bus.id_alu_src;
        capture_s.reg_write = bus.id_reg_write & bus.id_valid;
        capture_s.mem_read  = bus.id_mem_read & bus.id_valid;
        capture_s.mem_write = bus.id_mem_write & bus.id_valid;
    end

    // Pipeline register: flush bubble, hold, load-use bubble, or capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_r <= '0;
        end else if (bus.flush) begin
            ex_r <= '0;
        end else if (bus.ex_hold) begin
            ex_r <= ex_r;
        end else if (load_use_s) begin
            ex_r <= '0;
        end else begin
            ex_r <= capture_s;
        end
    end

    assign bus.ex_valid     = ex_r.valid;
    assign bus.ex_rs1       = ex_r.rs1;
    assign bus.ex_rs2       = ex_r.rs2;
    assign bus.ex_rd        = ex_r.rd;
    assign bus.ex_rs1_data  = ex_r.rs1_data;
    assign bus.ex_rs2_data  = ex_r.rs2_data;
    assign bus.ex_imm       = ex_r.imm;
    assign bus.ex_alu_op    = ex_r.alu_op;
    assign bus.ex_alu_src   = ex_r.alu_src;
    assign bus.ex_reg_write = ex_r.reg_write;
    assign bus.ex_mem_read  = ex_r.mem_read;
    assign bus.ex_mem_write = ex_r.mem_write;

`ifdef ID_EX_PERF_CNT_EN
    logic [15:0] stall_cnt_r;
    logic [15:0] flush_cnt_r;

    // Saturating event counters: real load-use bubbles and flushes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_r <= 16'h0000;
            flush_cnt_r <= 16'h0000;
        end else begin
            if (load_use_s & ~bus.flush & ~bus.ex_hold & (stall_cnt_r != 16'hFFFF)) begin
                stall_cnt_r <= stall_cnt_r + 16'h0001;
            end
            if (bus.flush & (flush_cnt_r != 16'hFFFF)) begin
                flush_cnt_r <= flush_cnt_r + 16'h0001;
            end
        end
    end

    assign stall_cnt = stall_cnt_r;
    assign flush_cnt = flush_cnt_r;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized scoreboard bench for id_ex_stage: the stimulus process predicts
// stall and the next EX slot from the stage's rules and queues them; monitor
// processes compare against the DUT before and after each rising edge.
module tb_id_ex_stage;
    localparam int DW = 16;
    localparam int AW = 4;
    localparam int OW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    id_ex_if #(.DATA_W(DW), .REG_AW(AW), .ALUOP_W(OW)) bus ();

`ifdef ID_EX_PERF_CNT_EN
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
    id_ex_stage #(.DATA_W(DW), .REG_AW(AW), .ALUOP_W(OW)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));
    int exp_stall_cnt = 0;
    int exp_flush_cnt = 0;
`else
    id_ex_stage #(.DATA_W(DW), .REG_AW(AW), .ALUOP_W(OW)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave));
`endif

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] rs1;
        logic [AW-1:0] rs2;
        logic [AW-1:0] rd;
        logic [DW-1:0] d1;
        logic [DW-1:0] d2;
        logic [DW-1:0] imm;
        logic [OW-1:0] op;
        logic          src;
        logic          rw;
        logic          mr;
        logic          mw;
    } ex_t;

    typedef struct packed {
        logic          rst;
        logic          hold;
        logic          flush;
        logic          idv;
        logic [AW-1:0] rs1;
        logic [AW-1:0] rs2;
        logic          uses;
        logic [AW-1:0] rd;
        logic [DW-1:0] d1;
        logic [DW-1:0] d2;
        logic [DW-1:0] imm;
        logic [OW-1:0] op;
        logic          src;
        logic          rw;
        logic          mr;
        logic          mw;
    } stim_t;

    int   checks = 0;
    int   errors = 0;
    logic stall_q[$];
    ex_t  ex_q[$];
    ex_t  model = '0;
    logic last_stall = 1'b0;

    function automatic void check(string name, logic [127:0] got, logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endfunction

    function automatic ex_t dut_ex();
        ex_t e;
        e = {bus.ex_valid, bus.ex_rs1, bus.ex_rs2, bus.ex_rd, bus.ex_rs1_data,
             bus.ex_rs2_data, bus.ex_imm, bus.ex_alu_op, bus.ex_alu_src,
             bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write};
        return e;
    endfunction

    function automatic stim_t nop();
        stim_t s;
        s = '0;
        return s;
    endfunction

    // Drive one cycle of stimulus and queue the predicted response.
    task automatic apply(input stim_t s);
        logic lu;
        logic st;
        ex_t  nxt;
        @(negedge clk);
        rst              = s.rst;
        bus.ex_hold      = s.hold;
        bus.flush        = s.flush;
        bus.id_valid     = s.idv;
        bus.id_rs1       = s.rs1;
        bus.id_rs2       = s.rs2;
        bus.id_uses_rs2  = s.uses;
        bus.id_rd        = s.rd;
        bus.id_rs1_data  = s.d1;
        bus.id_rs2_data  = s.d2;
        bus.id_imm       = s.imm;
        bus.id_alu_op    = s.op;
        bus.id_alu_src   = s.src;
        bus.id_reg_write = s.rw;
        bus.id_mem_read  = s.mr;
        bus.id_mem_write = s.mw;
        if (s.rst) model = '0;
        lu = model.valid && model.mr && (model.rd != 0) && s.idv &&
             ((model.rd == s.rs1) || (s.uses && (model.rd == s.rs2)));
        st = (lu || s.hold) && !s.flush;
        stall_q.push_back(st);
        if (s.rst || s.flush || (lu && !s.hold)) nxt = '0;
        else if (s.hold) nxt = model;
        else nxt = '{valid: s.idv, rs1: s.rs1, rs2: s.rs2, rd: s.rd, d1: s.d1,
                     d2: s.d2, imm: s.imm, op: s.op, src: s.src,
                     rw: s.rw && s.idv, mr: s.mr && s.idv, mw: s.mw && s.idv};
        ex_q.push_back(nxt);
`ifdef ID_EX_PERF_CNT_EN
        if (s.rst) begin
            exp_stall_cnt = 0;
            exp_flush_cnt = 0;
        end else begin
            if (lu && !s.flush && !s.hold && exp_stall_cnt < 65535) exp_stall_cnt++;
            if (s.flush && exp_flush_cnt < 65535) exp_flush_cnt++;
        end
`endif
        model = nxt;
        last_stall = st;
    endtask

    // Monitor: combinational stall, compared mid-cycle after inputs settle.
    initial begin
        logic e;
        forever begin
            @(negedge clk);
            #2;
            if (stall_q.size() > 0) begin
                e = stall_q.pop_front();
                check("stall", 128'(bus.stall), 128'(e));
            end
        end
    end

    // Monitor: registered EX slot, compared just after the rising edge.
    initial begin
        ex_t e;
        forever begin
            @(posedge clk);
            #1;
            if (ex_q.size() > 0) begin
                e = ex_q.pop_front();
                check("ex_slot", 128'(dut_ex()), 128'(e));
            end
        end
    end

    // Directed scenarios followed by randomized traffic.
    initial begin
        stim_t s;
        stim_t ld;
        rst = 1'b1;
        bus.ex_hold = 1'b0;
        bus.flush = 1'b0;
        bus.id_valid = 1'b0;
        bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_uses_rs2 = 1'b0; bus.id_rd = '0;
        bus.id_rs1_data = '0; bus.id_rs2_data = '0; bus.id_imm = '0;
        bus.id_alu_op = '0; bus.id_alu_src = 1'b0; bus.id_reg_write = 1'b0;
        bus.id_mem_read = 1'b0; bus.id_mem_write = 1'b0;
        #1;
        check("reset_slot", 128'(dut_ex()), 128'(0));
        repeat (2) @(posedge clk);

        // 1 pass-through
        s = nop(); s.idv = 1'b1; s.rs1 = 4'd2; s.rs2 = 4'd3; s.rd = 4'd4; s.rw = 1'b1;
        s.d1 = 16'h1234; s.imm = 16'hFFF0; s.op = 4'd5;
        apply(s);
        @(posedge clk); #1;
        check("t1_rd", 128'(bus.ex_rd), 128'(4));
        check("t1_valid", 128'(bus.ex_valid), 128'(1));

        // 2 load-use: one stall, one bubble, then capture
        ld = nop(); ld.idv = 1'b1; ld.rs1 = 4'd1; ld.rd = 4'd5; ld.rw = 1'b1; ld.mr = 1'b1;
        apply(ld);
        s = nop(); s.idv = 1'b1; s.rs1 = 4'd5; s.rd = 4'd8; s.rw = 1'b1; s.d1 = 16'hBEEF;
        apply(s);
        @(posedge clk); #1;
        check("t2_bubble", 128'(bus.ex_valid), 128'(0));
        apply(s);
        @(posedge clk); #1;
        check("t2_capture_rd", 128'(bus.ex_rd), 128'(8));

        // 3 rd=0 load and unused rs2 never stall
        ld.rd = 4'd0; apply(ld);
        s = nop(); s.idv = 1'b1; s.rs1 = 4'd0; s.rd = 4'd2; apply(s);
        ld.rd = 4'd6; apply(ld);
        s = nop(); s.idv = 1'b1; s.rs1 = 4'd1; s.rs2 = 4'd6; s.uses = 1'b0; s.rd = 4'd3; apply(s);

        // 4 flush together with load-use
        ld.rd = 4'd5; apply(ld);
        s = nop(); s.idv = 1'b1; s.rs1 = 4'd5; s.mr = 1'b1; s.rd = 4'd9; s.flush = 1'b1; apply(s);

        // 5 hold for three cycles with rd=7 in EX, then release
        s = nop(); s.idv = 1'b1; s.rd = 4'd7; s.rw = 1'b1; s.imm = 16'h00A5; apply(s);
        s = nop(); s.idv = 1'b1; s.rd = 4'd10; s.rw = 1'b1; s.hold = 1'b1;
        repeat (3) apply(s);
        s.hold = 1'b0; apply(s);
        @(posedge clk); #1;
        check("t5_release_rd", 128'(bus.ex_rd), 128'(10));

        // 6 asynchronous reset between edges while EX is valid
        check("t6_pre_valid", 128'(bus.ex_valid), 128'(1));
        s = nop(); s.rst = 1'b1; s.idv = 1'b1; s.rd = 4'd3; apply(s);
        #1;
        check("t6_async_clear", 128'(dut_ex()), 128'(0));
        s.rst = 1'b0; apply(s);

        // randomized traffic; stalled instructions are re-presented
        s = nop();
        for (int i = 0; i < 3000; i++) begin
            if (!last_stall) begin
                s.idv  = ($urandom_range(0, 9) != 0);
                s.rs1  = AW'($urandom_range(0, 7));
                s.rs2  = AW'($urandom_range(0, 7));
                s.uses = 1'($urandom_range(0, 1));
                s.rd   = AW'($urandom_range(0, 7));
                s.d1   = DW'($urandom);
                s.d2   = DW'($urandom);
                s.imm  = DW'($urandom);
                s.op   = OW'($urandom);
                s.src  = 1'($urandom_range(0, 1));
                s.rw   = 1'($urandom_range(0, 1));
                s.mr   = ($urandom_range(0, 2) == 0);
                s.mw   = ($urandom_range(0, 4) == 0);
            end
            s.hold  = ($urandom_range(0, 7) == 0);
            s.flush = ($urandom_range(0, 9) == 0);
            s.rst   = ($urandom_range(0, 299) == 0);
            apply(s);
        end
        s = nop();
        apply(s);
        repeat (3) @(posedge clk);
        #2;
        check("queues_drained", 128'(stall_q.size() + ex_q.size()), 128'(0));
`ifdef ID_EX_PERF_CNT_EN
        check("stall_cnt", 128'(stall_cnt), 128'(exp_stall_cnt));
        check("flush_cnt", 128'(flush_cnt), 128'(exp_flush_cnt));
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
